// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back stage.
//   memtoreg_e : write-back source select (ALU, load, link, immediate)
//   F3_*       : load funct3 encodings understood by the load aligner
//   wb_state_e : write-back control states
package wb_pkg;

  typedef enum logic [1:0] {
    MTR_ALU  = 2'b00,
    MTR_LOAD = 2'b01,
    MTR_LINK = 2'b10,
    MTR_IMM  = 2'b11
  } memtoreg_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    WAIT_MEM = 2'b01,
    COMMIT   = 2'b10
  } wb_state_e;

endpackage

// File: rtl/wb_stage_load_aligner.sv
// load_aligner: combinational load formatting.
//   fn3     : load funct3
//   addr_lo : byte offset within the word
//   raw     : aligned word returned by data memory
//   data    : byte/half selected and sign/zero extended, or the raw word
// Unknown funct3 codes pass the raw word through.
module load_aligner
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      fn3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] raw,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = raw[7:0];
    case (addr_lo)
      2'd1:    byte_sel = raw[15:8];
      2'd2:    byte_sel = raw[23:16];
      2'd3:    byte_sel = raw[31:24];
      default: byte_sel = raw[7:0];
    endcase
    // addr_lo[0] is a don't-care for halfword loads
    half_sel = addr_lo[1] ? raw[31:16] : raw[15:0];
  end

  always_comb begin
    data = raw;
    case (fn3)
      F3_LB:   data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LH:   data = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LW:   data = raw;
      F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LHU:  data = {{(XLEN-16){1'b0}}, half_sel};
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: write-back end of the datapath.
// Accepts a finished instruction, waits for the load response when the
// source is memory, formats it, and drives the register-file write port.
//   clk, reset            : clock, synchronous active-high reset
//   in_valid / in_ready   : upstream handshake (not ready while a load waits)
//   in_rd, in_reg_write   : destination and write intent
//   in_memtoreg           : source select (wb_pkg::memtoreg_e)
//   in_fn3, in_addr_lo    : load format controls
//   in_alu_result, in_pc_plus4, in_imm : candidate write-back values
//   mem_rsp_valid, mem_rdata : load response
//   wb_en, wb_rd, wb_data : register-file write port (wb_en pulses in COMMIT)
//   busy                  : load outstanding
// Optional macro WB_FWD_EN adds fwd_valid, fwd_data and pend_rd for
// forwarding and hazard detection.
module wb_stage
  import wb_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int RF_ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [RF_ADDR_W-1:0] in_rd,
  input  logic                 in_reg_write,
  input  logic [1:0]           in_memtoreg,
  input  logic [2:0]           in_fn3,
  input  logic [1:0]           in_addr_lo,
  input  logic [XLEN-1:0]      in_alu_result,
  input  logic [XLEN-1:0]      in_pc_plus4,
  input  logic [XLEN-1:0]      in_imm,
  input  logic                 mem_rsp_valid,
  input  logic [XLEN-1:0]      mem_rdata,
  output logic                 wb_en,
  output logic [RF_ADDR_W-1:0] wb_rd,
  output logic [XLEN-1:0]      wb_data,
  output logic                 busy
`ifdef WB_FWD_EN
  ,
  output logic                 fwd_valid,
  output logic [XLEN-1:0]      fwd_data,
  output logic [RF_ADDR_W-1:0] pend_rd
`endif
);

  wb_state_e              state_q, state_d;
  logic [RF_ADDR_W-1:0]   rd_q, rd_d;
  logic                   reg_write_q, reg_write_d;
  memtoreg_e              memtoreg_q, memtoreg_d;
  logic [2:0]             fn3_q, fn3_d;
  logic [1:0]             addr_lo_q, addr_lo_d;
  logic [XLEN-1:0]        data_q, data_d;

  logic                   accept;
  logic [XLEN-1:0]        src_data;
  logic [XLEN-1:0]        load_data;

  // Load formatting uses the fields latched at accept time.
  load_aligner #(.XLEN(XLEN)) u_align (
    .fn3     (fn3_q),
    .addr_lo (addr_lo_q),
    .raw     (mem_rdata),
    .data    (load_data)
  );

  assign in_ready = (state_q != WAIT_MEM);
  assign busy     = (state_q == WAIT_MEM);
  assign accept   = in_valid && in_ready;

  always_comb begin
    src_data = in_alu_result;
    case (memtoreg_e'(in_memtoreg))
      MTR_LINK: src_data = in_pc_plus4;
      MTR_IMM:  src_data = in_imm;
      default:  src_data = in_alu_result;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    rd_d        = rd_q;
    reg_write_d = reg_write_q;
    memtoreg_d  = memtoreg_q;
    fn3_d       = fn3_q;
    addr_lo_d   = addr_lo_q;
    data_d      = data_q;

    case (state_q)
      WAIT_MEM: begin
        if (mem_rsp_valid && memtoreg_q == MTR_LOAD) begin
          data_d  = load_data;
          state_d = COMMIT;
        end
      end
      COMMIT:  state_d = IDLE;
      default: state_d = state_q;
    endcase

    // A new accept (IDLE or COMMIT) overrides the default transition so
    // back-to-back results stream without a bubble. Loads leave data_q
    // alone so wb_data keeps its last committed value while waiting.
    if (accept) begin
      rd_d        = in_rd;
      reg_write_d = in_reg_write;
      memtoreg_d  = memtoreg_e'(in_memtoreg);
      fn3_d       = in_fn3;
      addr_lo_d   = in_addr_lo;
      if (memtoreg_e'(in_memtoreg) == MTR_LOAD) begin
        state_d = WAIT_MEM;
      end else begin
        state_d = COMMIT;
        data_d  = src_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      memtoreg_q  <= MTR_ALU;
      fn3_q       <= '0;
      addr_lo_q   <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
      memtoreg_q  <= memtoreg_d;
      fn3_q       <= fn3_d;
      addr_lo_q   <= addr_lo_d;
      data_q      <= data_d;
    end
  end

  assign wb_en   = (state_q == COMMIT) && reg_write_q && (rd_q != '0);
  assign wb_rd   = rd_q;
  assign wb_data = data_q;

`ifdef WB_FWD_EN
  assign fwd_valid = wb_en;
  assign fwd_data  = data_q;
  assign pend_rd   = (state_q == WAIT_MEM && reg_write_q && rd_q != '0) ? rd_q : '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Randomized scoreboard bench for wb_stage. Stimulus pushes the expected
// register-file write (rd, data, cycle) into a queue; a monitor on the
// falling edge pops and compares whenever wb_en is seen, and flags writes
// that are missing or unexpected.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic [1:0]  in_memtoreg;
  logic [2:0]  in_fn3;
  logic [1:0]  in_addr_lo;
  logic [31:0] in_alu_result, in_pc_plus4, in_imm;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        busy;
`ifdef WB_FWD_EN
  logic        fwd_valid;
  logic [31:0] fwd_data;
  logic [4:0]  pend_rd;
`endif

  wb_stage #(.XLEN(32), .RF_ADDR_W(5)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_reg_write(in_reg_write), .in_memtoreg(in_memtoreg),
    .in_fn3(in_fn3), .in_addr_lo(in_addr_lo),
    .in_alu_result(in_alu_result), .in_pc_plus4(in_pc_plus4), .in_imm(in_imm),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .busy(busy)
`ifdef WB_FWD_EN
    , .fwd_valid(fwd_valid), .fwd_data(fwd_data), .pend_rd(pend_rd)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [4:0]  last_rd;
  logic [31:0] last_data;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference load formatting from plain shift/mask arithmetic.
  function automatic logic [31:0] fmt_load(input logic [2:0] fn3, input logic [1:0] off,
                                           input logic [31:0] w);
    int unsigned b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * (off / 2))) & 32'hFFFF;
    case (fn3)
      3'd0:    return (b >= 128) ? b - 32'd256 : b;
      3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  // Monitor: every wb_en must match the queue head, including its cycle.
  always @(negedge clk) begin
    exp_t e;
    if (wb_en) begin
      if (q.size() == 0) begin
        chk("unexpected_wb_en", {27'd0, wb_rd}, 32'hFFFF_FFFF);
      end else begin
        e = q.pop_front();
        chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
        chk("wb_data", wb_data, e.data);
        chk("wb_cycle", cyc, e.cyc);
      end
    end else if (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      chk("wb_en_missing", {31'd0, wb_en}, 32'd1);
    end
`ifdef WB_FWD_EN
    if (fwd_valid !== wb_en || fwd_data !== wb_data) chk("fwd_mirror", fwd_data, wb_data);
`endif
  end

  task automatic clear_in();
    in_valid = 0; in_rd = 0; in_reg_write = 0; in_memtoreg = 0; in_fn3 = 0;
    in_addr_lo = 0; in_alu_result = 0; in_pc_plus4 = 0; in_imm = 0;
    mem_rsp_valid = 0; mem_rdata = 0;
  endtask

  // Issue one instruction; called just after a falling edge, returns after
  // the next falling edge (accept happens on the rising edge in between).
  task automatic issue(input logic [4:0] rd, input bit rw, input logic [1:0] mtr,
                       input logic [2:0] fn3, input logic [1:0] off, input logic [31:0] v);
    exp_t e;
    chk("in_ready_at_issue", {31'd0, in_ready}, 32'd1);
    in_valid = 1; in_rd = rd; in_reg_write = rw; in_memtoreg = mtr;
    in_fn3 = fn3; in_addr_lo = off;
    in_alu_result = $urandom; in_pc_plus4 = $urandom; in_imm = $urandom;
    case (mtr)
      2'd0: in_alu_result = v;
      2'd2: in_pc_plus4 = v;
      2'd3: in_imm = v;
      default: in_alu_result = {in_alu_result[31:2], off};
    endcase
    last_rd = rd;
    if (mtr != 2'd1) begin
      last_data = v;
      if (rw && rd != 0) begin
        e.rd = rd; e.data = v; e.cyc = cyc + 1;
        q.push_back(e);
      end
    end
    @(negedge clk);
    in_valid = 0;
  endtask

  // Full load: accept, wait k cycles (with junk offered upstream), respond.
  task automatic do_load(input logic [4:0] rd, input bit rw, input logic [2:0] fn3,
                         input logic [1:0] off, input logic [31:0] w, input int k);
    exp_t e;
    issue(rd, rw, 2'd1, fn3, off, 32'd0);
    for (int i = 0; i < k; i++) begin
      chk("busy_wait", {31'd0, busy}, 32'd1);
      chk("in_ready_wait", {31'd0, in_ready}, 32'd0);
      in_valid = $urandom_range(0, 1); in_rd = $urandom; in_memtoreg = 2'd0;
      in_reg_write = 1; in_alu_result = $urandom;
      @(negedge clk);
    end
    chk("busy_rsp", {31'd0, busy}, 32'd1);
    in_valid = 0;
    mem_rsp_valid = 1; mem_rdata = w;
    last_data = fmt_load(fn3, off, w);
    if (rw && rd != 0) begin
      e.rd = rd; e.data = last_data; e.cyc = cyc + 1;
      q.push_back(e);
    end
    @(negedge clk);
    mem_rsp_valid = 0;
  endtask

  task automatic idle_check(input string nm);
    @(negedge clk);
    chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
    chk({nm, "_ready"}, {31'd0, in_ready}, 32'd1);
    chk({nm, "_rd_hold"}, {27'd0, wb_rd}, {27'd0, last_rd});
    chk({nm, "_data_hold"}, wb_data, last_data);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_in();
    reset = 1;
    last_rd = 0; last_data = 0;
    repeat (2) @(negedge clk);
    chk("rst_wb_en", {31'd0, wb_en}, 32'd0);
    chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    reset = 0;
    @(negedge clk);

    // Directed cases
    issue(5'd5, 1, 2'd0, 3'd0, 2'd0, 32'h0000_1234);
    idle_check("alu");
    do_load(5'd7, 1, 3'd0, 2'd2, 32'h0080_0000, 3);   // LB -> FFFFFF80
    idle_check("lb");
    do_load(5'd8, 1, 3'd5, 2'd2, 32'h8001_0000, 1);   // LHU -> 00008001
    do_load(5'd9, 1, 3'd1, 2'd3, 32'h8001_0000, 0);   // LH, addr_lo[0] ignored
    issue(5'd1, 1, 2'd2, 3'd0, 2'd0, 32'h0000_0104);  // JAL link
    issue(5'd2, 1, 2'd3, 3'd0, 2'd0, 32'hABCD_E000);  // LUI, back-to-back
    idle_check("b2b");
    issue(5'd0, 1, 2'd0, 3'd0, 2'd0, 32'h0000_DEAD);  // rd=0: no write
    idle_check("rd0");
    mem_rsp_valid = 1; mem_rdata = 32'h1357_9BDF;     // stray response in IDLE
    @(negedge clk);
    mem_rsp_valid = 0;
    idle_check("stray_idle");
    do_load(5'd12, 0, 3'd2, 2'd0, 32'hCAFE_F00D, 2);  // reg_write=0 load still waits
    idle_check("nowrite_load");

    // Reset while a load is outstanding, then a stray response
    issue(5'd11, 1, 2'd1, 3'd2, 2'd0, 32'd0);
    @(negedge clk);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    reset = 1;
    @(negedge clk);
    reset = 0;
    mem_rsp_valid = 1; mem_rdata = 32'h1111_2222;
    @(negedge clk);
    mem_rsp_valid = 0;
    last_rd = 0; last_data = 0;
    chk("rst_wait_wb_rd", {27'd0, wb_rd}, 32'd0);
    chk("rst_wait_wb_data", wb_data, 32'd0);
    idle_check("rst_wait");

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      logic [4:0] rd;
      logic [1:0] mtr;
      rd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      mtr = 2'($urandom_range(0, 3));
      if (mtr == 2'd1)
        do_load(rd, $urandom_range(0, 5) != 0, 3'($urandom), 2'($urandom), $urandom,
                $urandom_range(0, 4));
      else
        issue(rd, $urandom_range(0, 5) != 0, mtr, 3'($urandom), 2'($urandom), $urandom);
      if ($urandom_range(0, 4) == 0) begin
        mem_rsp_valid = $urandom_range(0, 1); mem_rdata = $urandom;
        @(negedge clk);
        mem_rsp_valid = 0;
        idle_check("rand_gap");
      end
    end

    repeat (4) @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
